// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results are buffered in a small FIFO and drained on idle pipeline cycles.
module wb_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_we,
  input  logic [ADDR_W-1:0]       wb_waddr,
  input  logic [DATA_W-1:0]       wb_wdata,
  input  logic                    lt_valid,
  output logic                    lt_ready,
  input  logic [ADDR_W-1:0]       lt_waddr,
  input  logic [DATA_W-1:0]       lt_wdata,
  output logic                    we,
  output logic [ADDR_W-1:0]       waddr,
  output logic [DATA_W-1:0]       wdata,
  input  logic [ADDR_W-1:0]       chk_addr1,
  input  logic [ADDR_W-1:0]       chk_addr2,
  output logic                    chk_hit1,
  output logic                    chk_hit2,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              out_lt;
  logic [DEPTH-1:0]  entry_valid;

  logic lt_fire;
  logic wb_go;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic push;

  assign lt_ready   = !rst && (count < CW'(DEPTH));
  assign lt_fire    = lt_valid && lt_ready;
  assign wb_go      = wb_we && (wb_waddr != '0);
  assign fifo_empty = (count == '0);
  assign pop        = !wb_go && !fifo_empty;
  assign bypass     = !wb_go && fifo_empty && lt_fire && (lt_waddr != '0);
  assign push       = lt_fire && (lt_waddr != '0) && !bypass;
  assign fifo_count = count;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

  always_comb begin
    logic h1;
    logic h2;
    h1 = 1'b0;
    h2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (fifo_addr[i] == chk_addr1)) h1 = 1'b1;
      if (entry_valid[i] && (fifo_addr[i] == chk_addr2)) h2 = 1'b1;
    end
    if (lt_valid && (lt_waddr == chk_addr1)) h1 = 1'b1;
    if (lt_valid && (lt_waddr == chk_addr2)) h2 = 1'b1;
    if (we && out_lt && (waddr == chk_addr1)) h1 = 1'b1;
    if (we && out_lt && (waddr == chk_addr2)) h2 = 1'b1;
    chk_hit1 = h1 && (chk_addr1 != '0);
    chk_hit2 = h2 && (chk_addr2 != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lt_waddr;
      fifo_data[wr_ptr] <= lt_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      out_lt <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wb_go) begin
        we     <= 1'b1;
        waddr  <= wb_waddr;
        wdata  <= wb_wdata;
        out_lt <= 1'b0;
      end else if (pop) begin
        we     <= 1'b1;
        waddr  <= fifo_addr[rd_ptr];
        wdata  <= fifo_data[rd_ptr];
        out_lt <= 1'b1;
      end else if (bypass) begin
        we     <= 1'b1;
        waddr  <= lt_waddr;
        wdata  <= lt_wdata;
        out_lt <= 1'b1;
      end else begin
        we     <= 1'b0;
        out_lt <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
